// File: rtl/vector_shift_out_pkg.sv
// vector_shift_out_pkg: state encodings and default sizing for the vector shift-out block
// Contents: vso_state_t FSM encoding, DEF_WIDTH (chain length), DEF_DIV (SHCP/STCP half-period)
package vector_shift_out_pkg;
   localparam int DEF_WIDTH = 128;
   localparam int DEF_DIV = 4;
   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, CLR, CLR_LATCH, FINISH} vso_state_t;
endpackage

// File: rtl/clk_phase_timer.sv
// clk_phase_timer: DIV-cycle down-counter with load and terminal flag
// Ports: clk, rst (sync, active-high), load (restart a DIV-cycle phase), term (high in the last cycle of the phase)
module clk_phase_timer
   import vector_shift_out_pkg::*;
#(
   parameter int DIV = DEF_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic term
);
   localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
   logic [PW-1:0] cnt;
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else if (load) cnt <= PW'(DIV - 1);
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign term = cnt == '0;
endmodule

// File: rtl/vector_shift_out.sv
// vector_shift_out: serialises a vector MSB-first into a 595-style chain and latches it with one STCP pulse
// Ports: clk, rst (sync, active-high); vector/start request a shift-and-latch; clear requests a chain clear;
//        busy/done report progress; ds, shcp, stcp, mr_bar drive the chain (all registered)
module vector_shift_out
   import vector_shift_out_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIV = DEF_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] vector,
   input  logic             start,
   input  logic             clear,
   output logic             busy,
   output logic             done,
   output logic             ds,
   output logic             shcp,
   output logic             stcp,
   output logic             mr_bar
);
   localparam int BW = $clog2(WIDTH + 1);
   vso_state_t state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_sh;
   logic [BW-1:0] bcnt;
   logic term;
   // IDLE reloads every cycle so each timed state starts with a full DIV-cycle phase
   clk_phase_timer #(.DIV(DIV)) u_timer (
      .clk(clk),
      .rst(rst),
      .load(state == IDLE || term),
      .term(term)
   );
   assign sr_sh = sr << 1;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         sr <= '0;
         bcnt <= '0;
         ds <= 1'b0;
         shcp <= 1'b0;
         stcp <= 1'b0;
         mr_bar <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
      end else
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (clear) begin
                  state <= CLR;
                  busy <= 1'b1;
                  mr_bar <= 1'b0;
                  ds <= 1'b0;
                  shcp <= 1'b0;
               end else if (start) begin
                  state <= SHIFT_LO;
                  busy <= 1'b1;
                  sr <= vector;
                  bcnt <= BW'(WIDTH);
                  ds <= vector[WIDTH-1];
               end
            end
            SHIFT_LO:
               if (term) begin
                  state <= SHIFT_HI;
                  shcp <= 1'b1;
               end
            SHIFT_HI:
               if (term) begin
                  sr <= sr_sh;
                  bcnt <= bcnt - 1'b1;
                  shcp <= 1'b0;
                  if (bcnt == BW'(1)) begin
                     state <= LATCH;
                     stcp <= 1'b1;
                  end else begin
                     // DS only moves on SHIFT_LO entry, giving a full phase of setup
                     state <= SHIFT_LO;
                     ds <= sr_sh[WIDTH-1];
                  end
               end
            LATCH, CLR_LATCH:
               if (term) begin
                  state <= FINISH;
                  stcp <= 1'b0;
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            CLR:
               if (term) begin
                  state <= CLR_LATCH;
                  mr_bar <= 1'b1;
                  stcp <= 1'b1;
               end
            FINISH: begin
               state <= IDLE;
               done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_vector_shift_out.sv
// tb_vector_shift_out: directed checks of vector_shift_out in three configurations against behavioural 595 models
module tb_vector_shift_out;
   logic clk = 1'b0;
   logic rst, start, clear;
   logic [127:0] vec;
   int sel;
   int checks = 0, errors = 0;
   logic [5:0] a_o, b_o, c_o, o;
   always #5 clk = ~clk;
   // output bus order: {busy, done, ds, shcp, stcp, mr_bar}
   vector_shift_out #(.WIDTH(8), .DIV(2)) dut_a (
      .clk(clk), .rst(rst), .vector(vec[7:0]), .start(start && sel == 0), .clear(clear && sel == 0),
      .busy(a_o[5]), .done(a_o[4]), .ds(a_o[3]), .shcp(a_o[2]), .stcp(a_o[1]), .mr_bar(a_o[0]));
   vector_shift_out dut_b (
      .clk(clk), .rst(rst), .vector(vec), .start(start && sel == 1), .clear(clear && sel == 1),
      .busy(b_o[5]), .done(b_o[4]), .ds(b_o[3]), .shcp(b_o[2]), .stcp(b_o[1]), .mr_bar(b_o[0]));
   vector_shift_out #(.WIDTH(4), .DIV(1)) dut_c (
      .clk(clk), .rst(rst), .vector(vec[3:0]), .start(start && sel == 2), .clear(clear && sel == 2),
      .busy(c_o[5]), .done(c_o[4]), .ds(c_o[3]), .shcp(c_o[2]), .stcp(c_o[1]), .mr_bar(c_o[0]));
   assign o = sel == 0 ? a_o : sel == 1 ? b_o : c_o;
   // behavioural 74HC595 chains: shift on SHCP rise, async clear on MR_BAR low, latch on STCP rise
   logic [7:0] ma_sh, ma_q;
   logic [127:0] mb_sh, mb_q;
   logic [3:0] mc_sh, mc_q;
   always @(posedge a_o[2] or negedge a_o[0]) if (!a_o[0]) ma_sh <= '0; else ma_sh <= {ma_sh[6:0], a_o[3]};
   always @(posedge a_o[1]) ma_q <= ma_sh;
   always @(posedge b_o[2] or negedge b_o[0]) if (!b_o[0]) mb_sh <= '0; else mb_sh <= {mb_sh[126:0], b_o[3]};
   always @(posedge b_o[1]) mb_q <= mb_sh;
   always @(posedge c_o[2] or negedge c_o[0]) if (!c_o[0]) mc_sh <= '0; else mc_sh <= {mc_sh[2:0], c_o[3]};
   always @(posedge c_o[1]) mc_q <= mc_sh;
   // observation results (cycle k = k-th cycle after the request cycle)
   int nrise, first_rise, stcp_first, stcp_hi, done_at, ndone, mr_first, mr_low, busy_gap, ntog;
   logic [127:0] rbits;
   task automatic observe(input int n, input int mid_k);
      logic ps, pst;
      nrise = 0; rbits = '0; first_rise = -1; stcp_first = -1; stcp_hi = 0; done_at = -1;
      ndone = 0; mr_first = -1; mr_low = 0; busy_gap = 0; ntog = 0;
      ps = o[2]; pst = o[1];
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (o[2] && !ps) begin
            nrise++;
            rbits = {rbits[126:0], o[3]};
            if (first_rise < 0) first_rise = k;
         end
         if (o[2] != ps) ntog++;
         if (o[1] && !pst && stcp_first < 0) stcp_first = k;
         if (o[1]) stcp_hi++;
         if (o[4]) begin ndone++; if (done_at < 0) done_at = k; end
         if (!o[0]) begin mr_low++; if (mr_first < 0) mr_first = k; end
         if (done_at < 0 && !o[5]) busy_gap++;
         ps = o[2]; pst = o[1];
         start = k == mid_k;
         clear = 1'b0;
         if (k == mid_k) vec = ~vec;
      end
   endtask
   task automatic kick(input int s, input logic [127:0] v, input logic st, input logic cl);
      @(negedge clk);
      sel = s; vec = v; start = st; clear = cl;
   endtask
   task automatic test_reset;
      rst = 1'b1; start = 1'b0; clear = 1'b0; vec = '0; sel = 0;
      repeat (3) @(negedge clk);
      checks += 3;
      if (a_o !== 6'b000001) begin errors++; $display("FAIL reset_a: got %b expected 000001", a_o); end
      if (b_o !== 6'b000001) begin errors++; $display("FAIL reset_b: got %b expected 000001", b_o); end
      if (c_o !== 6'b000001) begin errors++; $display("FAIL reset_c: got %b expected 000001", c_o); end
      rst = 1'b0;
   endtask
   task automatic test_basic;
      kick(0, 128'hA5, 1'b1, 1'b0);
      observe(40, 0);
      checks += 7;
      if (nrise !== 8 || rbits[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_ds: %0d rises bits %h expected 8 rises bits a5", nrise, rbits[7:0]); end
      if (first_rise !== 3) begin errors++; $display("FAIL basic_first_shcp: got %0d expected 3", first_rise); end
      if (stcp_first !== 33) begin errors++; $display("FAIL basic_stcp_at: got %0d expected 33", stcp_first); end
      if (stcp_hi !== 2) begin errors++; $display("FAIL basic_stcp_width: got %0d expected 2", stcp_hi); end
      if (done_at !== 35) begin errors++; $display("FAIL basic_done_at: got %0d expected 35", done_at); end
      if (ndone !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", ndone); end
      if (ma_q !== 8'hA5) begin errors++; $display("FAIL basic_model: got %h expected a5", ma_q); end
   endtask
   task automatic test_clear;
      kick(0, 128'hFF, 1'b1, 1'b0);
      observe(40, 0);
      checks++;
      if (ma_q !== 8'hFF) begin errors++; $display("FAIL clear_prelatch: got %h expected ff", ma_q); end
      kick(0, 128'h0, 1'b0, 1'b1);
      observe(10, 0);
      checks += 5;
      if (mr_first !== 1 || mr_low !== 2) begin errors++; $display("FAIL clear_mr: first %0d len %0d expected 1 and 2", mr_first, mr_low); end
      if (stcp_first !== 3 || stcp_hi !== 2) begin errors++; $display("FAIL clear_stcp: first %0d len %0d expected 3 and 2", stcp_first, stcp_hi); end
      if (nrise !== 0) begin errors++; $display("FAIL clear_shcp: got %0d rises expected 0", nrise); end
      if (done_at !== 5) begin errors++; $display("FAIL clear_done_at: got %0d expected 5", done_at); end
      if (ma_q !== 8'h00) begin errors++; $display("FAIL clear_model: got %h expected 00", ma_q); end
   endtask
   task automatic test_priority;
      kick(0, 128'hFF, 1'b1, 1'b1);
      observe(10, 0);
      checks += 3;
      if (nrise !== 0) begin errors++; $display("FAIL prio_shcp: got %0d rises expected 0", nrise); end
      if (done_at !== 5 || mr_low !== 2) begin errors++; $display("FAIL prio_clear_seq: done %0d mr_low %0d expected 5 and 2", done_at, mr_low); end
      if (ma_q !== 8'h00) begin errors++; $display("FAIL prio_model: got %h expected 00", ma_q); end
      kick(0, 128'hC3, 1'b1, 1'b0);
      observe(40, 10);
      checks += 3;
      if (nrise !== 8 || rbits[7:0] !== 8'hC3) begin errors++; $display("FAIL ignore_shcp: %0d rises bits %h expected 8 rises bits c3", nrise, rbits[7:0]); end
      if (ndone !== 1 || done_at !== 35) begin errors++; $display("FAIL ignore_done: count %0d at %0d expected 1 at 35", ndone, done_at); end
      if (ma_q !== 8'hC3) begin errors++; $display("FAIL ignore_model: got %h expected c3", ma_q); end
   endtask
   task automatic test_reset_mid;
      kick(0, 128'h81, 1'b1, 1'b0);
      observe(40, 0);
      kick(0, 128'h3C, 1'b1, 1'b0);
      observe(11, 0);
      checks++;
      if (nrise !== 3) begin errors++; $display("FAIL rstmid_rises: got %0d expected 3", nrise); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (a_o !== 6'b000001) begin errors++; $display("FAIL rstmid_outputs: got %b expected 000001", a_o); end
      rst = 1'b0;
      observe(20, 0);
      checks += 2;
      if (stcp_first !== -1 || ndone !== 0) begin errors++; $display("FAIL rstmid_quiet: stcp at %0d done %0d expected none", stcp_first, ndone); end
      if (ma_q !== 8'h81) begin errors++; $display("FAIL rstmid_model: got %h expected 81", ma_q); end
      kick(0, 128'h5A, 1'b1, 1'b0);
      observe(40, 0);
      checks += 2;
      if (done_at !== 35) begin errors++; $display("FAIL restart_done_at: got %0d expected 35", done_at); end
      if (ma_q !== 8'h5A) begin errors++; $display("FAIL restart_model: got %h expected 5a", ma_q); end
   endtask
   task automatic test_defaults;
      logic [127:0] v;
      v = '0; v[127] = 1'b1; v[0] = 1'b1;
      kick(1, v, 1'b1, 1'b0);
      observe(1040, 0);
      checks += 5;
      if (done_at !== 1029 || ndone !== 1) begin errors++; $display("FAIL def_done: at %0d count %0d expected 1029 and 1", done_at, ndone); end
      if (busy_gap !== 0) begin errors++; $display("FAIL def_busy: %0d low cycles before done expected 0", busy_gap); end
      if (nrise !== 128) begin errors++; $display("FAIL def_rises: got %0d expected 128", nrise); end
      if (rbits !== v) begin errors++; $display("FAIL def_ds: got %h expected %h", rbits, v); end
      if (mb_q !== v) begin errors++; $display("FAIL def_model: got %h expected %h", mb_q, v); end
   endtask
   task automatic test_div1;
      kick(2, 128'h9, 1'b1, 1'b0);
      observe(14, 0);
      checks += 5;
      if (first_rise !== 2 || nrise !== 4) begin errors++; $display("FAIL div1_shcp: first %0d count %0d expected 2 and 4", first_rise, nrise); end
      if (ntog !== 8) begin errors++; $display("FAIL div1_toggle: got %0d toggles expected 8", ntog); end
      if (stcp_first !== 9 || stcp_hi !== 1) begin errors++; $display("FAIL div1_stcp: at %0d len %0d expected 9 and 1", stcp_first, stcp_hi); end
      if (done_at !== 10) begin errors++; $display("FAIL div1_done_at: got %0d expected 10", done_at); end
      if (mc_q !== 4'h9) begin errors++; $display("FAIL div1_model: got %h expected 9", mc_q); end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_clear;
      test_priority;
      test_reset_mid;
      test_defaults;
      test_div1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
